// File: rtl/sync_counter_pkg.sv
// Shared definitions for the synchronous D-flop counter: default width and count type.
package sync_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/sync_counter_inf.sv
// Signal bundle used by the verification environment to drive and observe the counter.
interface sync_counter_inf
    import sync_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic clk
);

    logic             rst;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;

    modport dut (input clk, input rst, output q, output qbar);
    modport env (input clk, output rst, input q, input qbar);

endinterface

// File: rtl/dff.sv
// One-bit D flip-flop with synchronous active-high reset and complementary output.
module dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic qbar
);

    logic state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 1'b0;
        end else begin
            state_q <= d;
        end
    end

    // Both outputs come from the same storage bit, so they can never disagree.
    assign q    = state_q;
    assign qbar = ~state_q;

endmodule

// File: rtl/d_sync_counter.sv
// Free-running synchronous up counter: a toggle-carry chain feeding WIDTH D flops on one clock.
module d_sync_counter
    import sync_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    logic [WIDTH-1:0] d;
    // carry[i] is the AND of all bits below i; bit 0 always toggles.
    logic [WIDTH-1:0] carry;

    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            carry[i] = carry[i-1] & q[i-1];
        end
        d = q ^ carry;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff u_dff (
            .clk  (clk),
            .rst  (rst),
            .d    (d[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

endmodule

// File: tb/tb_d_sync_counter.sv
// Self-checking bench: vector table, directed corner sequences and randomized reset/count stream.
module tb_d_sync_counter;
    import sync_counter_pkg::*;

    typedef struct {
        logic   rst;
        count_t q;
    } vec_t;

    logic       clk;
    logic       rst4;
    logic       rst3;
    count_t     q4;
    count_t     qbar4;
    logic [2:0] q3;
    logic [2:0] qbar3;

    int vectors;
    int miscompares;

    d_sync_counter #(.WIDTH(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst4),
        .q    (q4),
        .qbar (qbar4)
    );

    d_sync_counter #(.WIDTH(3)) u_dut3 (
        .clk  (clk),
        .rst  (rst3),
        .q    (q3),
        .qbar (qbar3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive rst for one edge on the 4-bit counter and check q/qbar after it.
    task automatic step4(input string name, input logic r, input count_t exp);
        count_t nexp;
        nexp = ~exp;
        rst4 = r;
        @(posedge clk);
        #1;
        check({name, ".q"}, 32'(q4), 32'(exp));
        check({name, ".qbar"}, 32'(qbar4), 32'(nexp));
    endtask

    task automatic step3(input string name, input logic r, input logic [2:0] exp);
        logic [2:0] nexp;
        nexp = ~exp;
        rst3 = r;
        @(posedge clk);
        #1;
        check({name, ".q"}, 32'(q3), 32'(exp));
        check({name, ".qbar"}, 32'(qbar3), 32'(nexp));
    endtask

    vec_t tbl[$];
    int   model;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst4        = 1'b1;
        rst3        = 1'b1;
        #1;

        // Reset for two edges, then ten counts, then a one-edge reset and restart.
        tbl.push_back('{rst: 1'b1, q: 4'h0});
        tbl.push_back('{rst: 1'b1, q: 4'h0});
        for (int i = 1; i <= 10; i++) tbl.push_back('{rst: 1'b0, q: count_t'(i)});
        tbl.push_back('{rst: 1'b1, q: 4'h0});
        tbl.push_back('{rst: 1'b0, q: 4'h1});
        tbl.push_back('{rst: 1'b0, q: 4'h2});
        foreach (tbl[i]) step4("table", tbl[i].rst, tbl[i].q);
        check("table_end_q", 32'(q4), 32'h2);

        // Wrap: 16 edges from 0 pass E, F and return to 0.
        step4("wrap_rst", 1'b1, 4'h0);
        for (int i = 1; i <= 16; i++) step4("wrap", 1'b0, count_t'(i % 16));

        // Reset mid-count at q=7, then resume.
        step4("mid_rst0", 1'b1, 4'h0);
        for (int i = 1; i <= 7; i++) step4("mid_up", 1'b0, count_t'(i));
        step4("mid_rst", 1'b1, 4'h0);
        step4("mid_after1", 1'b0, 4'h1);
        step4("mid_after2", 1'b0, 4'h2);

        // Held reset for five edges from a nonzero value.
        for (int i = 0; i < 5; i++) step4("held_rst", 1'b1, 4'h0);
        step4("held_release", 1'b0, 4'h1);

        // Randomized reset/count stream against an arithmetic model.
        model = 1;
        for (int i = 0; i < 200; i++) begin
            logic r;
            r     = ($urandom_range(7) == 0);
            model = r ? 0 : (model + 1) % 16;
            step4("random", r, count_t'(model));
        end

        // WIDTH=3: reset, then 9 edges give 1..7, 0, 1.
        step3("w3_rst", 1'b1, 3'd0);
        for (int i = 1; i <= 9; i++) step3("w3", 1'b0, 3'(i % 8));
        check("w3_final_qbar", 32'(qbar3), 32'(3'b110));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/d_sync_counter.md
Name: d_sync_counter

Overview:
- Free-running synchronous binary up counter built from a chain of D flip-flops sharing one clock.
- Every flop updates on the same rising clock edge; there is no ripple clocking.
- Exposes the count (q) and its bitwise complement (qbar).
- Used as a standalone counting/timing block; the verification environment drives it through the sync_counter_inf interface (clk, rst, q, qbar).

Parameters:
- WIDTH, 4, number of counter bits. Legal range is 1..32. Count modulus is 2**WIDTH.

Ports:
- clk  input  1  system clock. All state changes occur on the rising edge.
- rst  input  1  synchronous, active-high reset. Sampled only on the rising edge of clk.
- q  output  WIDTH  current count value, unsigned.
- qbar  output  WIDTH  bitwise complement of q.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. The polarity and synchronicity are fixed.
- Reset:
  - On a rising edge with rst=1: q <= 0 and qbar <= all ones (4'hF at default width).
  - Reset takes priority over counting.
  - Holding rst high keeps q=0 for every edge it is sampled high.
  - rst has no effect between edges.
- Count:
  - On a rising edge with rst=0: q <= q + 1 modulo 2**WIDTH.
  - Latency is one clock: the value visible after edge N is the pre-edge value plus one.
- Wrap-around: max value (4'hF at default) -> 0 on the next non-reset edge. No overflow flag and no saturation.
- First count after reset release: if rst is sampled low on edge k, q=1 after edge k, provided rst was high on edge k-1.
- Reset mid-operation: from any value, the next edge with rst=1 gives q=0. Counting resumes from 0 at the first edge with rst=0.
- Power-up: q and qbar are undefined until the first reset edge. Benches must apply rst for at least one clock before checking.
- Invariant: qbar == ~q at all times after the first reset. Both are registered outputs from the same flops (qbar is the flop's complementary output), so no glitch or skew appears between them.
- Next-state logic, per bit i:
  - d[i] = q[i] XOR (AND of q[i-1:0]).
  - d[0] = ~q[0].
  - This is the synchronous toggle-carry form; it yields exactly +1.
- No combinational path from inputs to outputs.

Decomposition:
- Package sync_counter_pkg:
  - localparam DEFAULT_WIDTH = 4.
  - typedef for the count vector at DEFAULT_WIDTH.
  - shared by RTL, interface and environment.
- Sub-module dff: one-bit D flip-flop.
  - Ports: clk, rst, d, q, qbar.
  - Synchronous active-high reset to q=0, qbar=1.
  - Instantiated WIDTH times via a generate loop.
- Top level contains only the carry/AND chain and the generate loop.

Test Plan:
- Reset: rst=1 for 2 edges -> q=4'h0, qbar=4'hF after each edge.
- Basic count: release rst, apply 10 edges -> q steps 1,2,...,10 (4'hA), qbar=4'h5 at the end. Check q == previous+1 every cycle.
- Wrap: count from 0 for 16 edges -> q passes 4'hE, 4'hF, then 4'h0. qbar goes 4'h0 -> 4'hF at the wrap.
- Mid-count reset: at q=7, assert rst for 1 edge -> q=0. Deassert -> next edges give 1, 2.
- Held reset and invariant: rst high for 5 edges -> q stays 0. Throughout a 50-edge run, assert qbar == ~q on every edge.
- Width parameter: WIDTH=3, 9 edges after reset -> sequence 1..7, 0, 1. qbar=3'b110 at the final value 1.
